// File: rtl/pll_ctrl_pkg.sv
// rtl/pll_ctrl_pkg.sv - shared state type and constants for the PLL reset sequencer
package pll_ctrl_pkg;

  // Sequencer states; the encoding is visible on the debug state port
  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } pll_state_t;

  // Saturation value of the 8-bit event counters
  localparam logic [7:0] PLL_CNT_SAT = 8'hFF;

  // Saturating increment used by the retry and lock-loss counters
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == PLL_CNT_SAT) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for a single asynchronous bit
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage capture; the first stage may go metastable, only q is used
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_ctrl.sv
// rtl/pll_reset_ctrl.sv - PLL reset/lock sequencer; PLL_CTRL_RETRY_EN enables timeout retries
module pll_reset_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 250000,
  parameter int STABLE_CYCLES = 2500,
  parameter int CNT_W         = 18
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       locked,
  input  logic       restart,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       ready,
  output logic [7:0] retry_cnt,
  output logic [7:0] lost_cnt,
  output logic [1:0] state
);

  // Terminal counts of the shared cycle counter in each timed state
  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);

  pll_state_t       state_q;
  pll_state_t       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             locked_s;
  logic             lost_hit;
`ifdef PLL_CTRL_RETRY_EN
  logic             retry_hit;
`endif

  // LOCK comes from the PLL domain; only the synchronized copy is used
  sync_2ff u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (locked),
    .q     (locked_s)
  );

  // Next-state, shared counter and event decode; restart overrides everything
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_W'(1);
    lost_hit  = 1'b0;
`ifdef PLL_CTRL_RETRY_EN
    retry_hit = 1'b0;
`endif
    case (state_q)
      PLL_RST: begin
        if (cnt_q == RST_LAST) begin
          state_d = WAIT_LOCK;
        end
      end
      WAIT_LOCK: begin
        if (locked_s) begin
          state_d = STABLE;
        end else if (cnt_q == LOCK_LAST) begin
`ifdef PLL_CTRL_RETRY_EN
          state_d   = PLL_RST;
          retry_hit = 1'b1;
`else
          // Without retries the wait simply continues; hold the counter
          cnt_d = cnt_q;
`endif
        end
      end
      STABLE: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = RUN;
        end
      end
      RUN: begin
        // Nothing is timed in RUN, so keep the counter still
        cnt_d = cnt_q;
        if (!locked_s) begin
          state_d  = PLL_RST;
          lost_hit = 1'b1;
        end
      end
      default: begin
        state_d = PLL_RST;
      end
    endcase

    if (restart) begin
      state_d   = PLL_RST;
      lost_hit  = 1'b0;
`ifdef PLL_CTRL_RETRY_EN
      retry_hit = 1'b0;
`endif
    end

    // Every transition, including a restart into PLL_RST, starts timing afresh
    if (restart || (state_d != state_q)) begin
      cnt_d = '0;
    end
  end

  // State, counter and outputs; outputs decode the next state so they move with it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= PLL_RST;
      cnt_q     <= '0;
      pll_rst   <= 1'b1;
      sys_rst_n <= 1'b0;
      ready     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pll_rst   <= (state_d == PLL_RST);
      sys_rst_n <= (state_d == RUN);
      ready     <= (state_d == RUN);
    end
  end

  // Lock losses seen from RUN, saturating, cleared only by rst_n
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lost_cnt <= '0;
    end else if (lost_hit) begin
      lost_cnt <= sat_inc8(lost_cnt);
    end
  end

`ifdef PLL_CTRL_RETRY_EN
  // Lock-timeout retries, saturating, cleared only by rst_n
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retry_cnt <= '0;
    end else if (retry_hit) begin
      retry_cnt <= sat_inc8(retry_cnt);
    end
  end
`else
  assign retry_cnt = '0;
`endif

  assign state = state_q;

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// tb/tb_pll_reset_ctrl.sv - self-checking bench for pll_reset_ctrl against a timestamp-based model
module tb_pll_reset_ctrl;

  localparam int RC = 4;
  localparam int LT = 20;
  localparam int SC = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       locked;
  logic       restart;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       ready;
  logic [7:0] retry_cnt;
  logic [7:0] lost_cnt;
  logic [1:0] state;

  int total = 0;
  int bad   = 0;

  // Reference model: phase, edge index at which it was entered, edges since reset
  int m_phase;
  int m_start;
  int m_edges;
  int m_retry;
  int m_lost;
  int lk_hist[$];
  int steps = 0;

  pll_reset_ctrl #(
    .RST_CYCLES    (RC),
    .LOCK_TIMEOUT  (LT),
    .STABLE_CYCLES (SC),
    .CNT_W         (18)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .locked    (locked),
    .restart   (restart),
    .pll_rst   (pll_rst),
    .sys_rst_n (sys_rst_n),
    .ready     (ready),
    .retry_cnt (retry_cnt),
    .lost_cnt  (lost_cnt),
    .state     (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (step %0d)", tag, got, exp, steps);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_start = 0;
    m_edges = 0;
    m_retry = 0;
    m_lost  = 0;
    lk_hist = '{0, 0};
  endtask

  // Lock seen by the sequencer lags the pin by two edges; elapsed time is a timestamp difference
  task automatic model_edge(input int lk_now, input int rs);
    int ls;
    int el;
    int nxt;
    ls  = lk_hist.pop_front();
    lk_hist.push_back(lk_now);
    el  = m_edges - m_start;
    nxt = m_phase;
    if (rs != 0) begin
      nxt = 0;
    end else begin
      case (m_phase)
        0: if (el >= RC - 1) nxt = 1;
        1: begin
          if (ls != 0) nxt = 2;
`ifdef PLL_CTRL_RETRY_EN
          else if (el >= LT - 1) begin
            nxt = 0;
            if (m_retry < 255) m_retry++;
          end
`endif
        end
        2: begin
          if (ls == 0) nxt = 1;
          else if (el >= SC - 1) nxt = 3;
        end
        default: begin
          if (ls == 0) begin
            nxt = 0;
            if (m_lost < 255) m_lost++;
          end
        end
      endcase
    end
    if (rs != 0 || nxt != m_phase) m_start = m_edges + 1;
    m_phase = nxt;
    m_edges++;
  endtask

  task automatic step(input int lk, input int rs);
    locked  = lk[0];
    restart = rs[0];
    @(posedge clk);
    model_edge(lk, rs);
    @(negedge clk);
    restart = 1'b0;
    steps++;
    check("model.pll_rst",   int'(pll_rst),   int'(m_phase == 0));
    check("model.sys_rst_n", int'(sys_rst_n), int'(m_phase == 3));
    check("model.ready",     int'(ready),     int'(m_phase == 3));
    check("model.state",     int'(state),     m_phase);
    check("model.retry_cnt", int'(retry_cnt), m_retry);
    check("model.lost_cnt",  int'(lost_cnt),  m_lost);
  endtask

  task automatic to_run();
    int n;
    n = 0;
    do begin
      step(1, 0);
      n++;
    end while (!ready && n < 100);
    check("to_run.ready", int'(ready), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int rises;
    int last_rise;
    int prev_rise;
    int prev_p;
    int seen_rel;
    int lk;
    int len;

    rst_n   = 1'b0;
    locked  = 1'b0;
    restart = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);

    check("reset.pll_rst",   int'(pll_rst),   1);
    check("reset.sys_rst_n", int'(sys_rst_n), 0);
    check("reset.ready",     int'(ready),     0);
    check("reset.state",     int'(state),     0);
    check("reset.retry_cnt", int'(retry_cnt), 0);
    check("reset.lost_cnt",  int'(lost_cnt),  0);

    // Boot: reset pulse width, then lock-to-release latency
    rst_n = 1'b1;
    n = 0;
    do begin
      step(0, 0);
      n++;
    end while (pll_rst && n < 50);
    check("boot.rst_width", n, RC);
    repeat (10 - RC) step(0, 0);
    n = 0;
    do begin
      step(1, 0);
      n++;
    end while (!sys_rst_n && n < 100);
    check("boot.latency", n, 2 + SC + 1);
    check("boot.ready", int'(ready), 1);
    check("boot.state", int'(state), 3);

    // Lock loss from RUN: visible on the third edge
    step(0, 0);
    step(0, 0);
    check("loss.still_run", int'(sys_rst_n), 1);
    step(0, 0);
    check("loss.sys_rst_n", int'(sys_rst_n), 0);
    check("loss.pll_rst",   int'(pll_rst),   1);
    check("loss.lost_cnt",  int'(lost_cnt),  1);

    // Restart coinciding with the loss of lock in RUN
    to_run();
    step(0, 0);
    step(0, 0);
    step(0, 1);
    check("collide.state",    int'(state),    0);
    check("collide.pll_rst",  int'(pll_rst),  1);
    check("collide.lost_cnt", int'(lost_cnt), 1);

    // Lock timeout behaviour, starting from RUN with a restart
    to_run();
    rises = 0;
    last_rise = 0;
    prev_rise = 0;
    prev_p = int'(pll_rst);
    for (int i = 1; i <= 1 + 3 * (LT + RC); i++) begin
      step(0, (i == 1) ? 1 : 0);
      if (pll_rst && prev_p == 0) begin
        rises++;
        prev_rise = last_rise;
        last_rise = i;
      end
      prev_p = int'(pll_rst);
    end
    check("timeout.lost_cnt", int'(lost_cnt), 1);
`ifdef PLL_CTRL_RETRY_EN
    check("timeout.retry_cnt", int'(retry_cnt), 3);
    check("timeout.rises", rises, 4);
    check("timeout.period", last_rise - prev_rise, LT + RC);
`else
    check("timeout.retry_cnt", int'(retry_cnt), 0);
    check("timeout.rises", rises, 1);
    check("timeout.state", int'(state), 1);
`endif

    // Lock glitch in the middle of STABLE
    step(0, 1);
    repeat (RC) step(0, 0);
    seen_rel = 0;
    repeat (6) begin
      step(1, 0);
      if (sys_rst_n) seen_rel = 1;
    end
    check("glitch.in_stable", int'(state), 2);
    repeat (3) begin
      step(0, 0);
      if (sys_rst_n) seen_rel = 1;
    end
    check("glitch.back_wait", int'(state), 1);
    check("glitch.no_release", seen_rel, 0);
    n = 0;
    do begin
      step(1, 0);
      n++;
    end while (!sys_rst_n && n < 100);
    check("glitch.relock_latency", n, 2 + SC + 1);

    // Saturation of the lock-loss counter
    for (int r = 0; r < 300; r++) begin
      repeat (3) step(0, 0);
      to_run();
    end
    check("sat.lost_cnt", int'(lost_cnt), 255);

    // Asynchronous reset while in STABLE
    step(0, 1);
    repeat (RC) step(0, 0);
    repeat (6) step(1, 0);
    check("areset.in_stable", int'(state), 2);
    #2;
    rst_n = 1'b0;
    #1;
    check("areset.pll_rst",   int'(pll_rst),   1);
    check("areset.sys_rst_n", int'(sys_rst_n), 0);
    check("areset.state",     int'(state),     0);
    check("areset.retry_cnt", int'(retry_cnt), 0);
    check("areset.lost_cnt",  int'(lost_cnt),  0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized lock patterns with occasional restarts
    n = 0;
    while (n < 3000) begin
      lk  = ($urandom_range(0, 3) != 0) ? 1 : 0;
      len = $urandom_range(1, 40);
      for (int k = 0; k < len; k++) begin
        step(lk, ($urandom_range(0, 63) == 0) ? 1 : 0);
        n++;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
